// File: rtl/sweep_peak_ctrl_if.sv
// ADC sample handshake and max-voltage holding register path of the sweep controller.
// The controller side is master; the ADC/holding-register side is slave.
interface sweep_peak_ctrl_if;
    logic [9:0] ADC_DATA;
    logic       ADC_VALID;
    logic [9:0] LV;
    logic       SAMPLE_REQ;
    logic [9:0] PV;
    logic       GT;

    modport master (input ADC_DATA, ADC_VALID, LV, output SAMPLE_REQ, PV, GT);
    modport slave  (output ADC_DATA, ADC_VALID, LV, input SAMPLE_REQ, PV, GT);
endinterface

// File: rtl/sweep_peak_ctrl.sv
// Servo sweep sequencer: move, settle, sample, compare against the held maximum,
// then park at the best position found and report completion.
module sweep_peak_ctrl #(
    parameter int POS_W      = 8,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 180,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 50000,
    parameter int ADC_TMO    = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    sweep_peak_ctrl_if.master bus,
    output logic [POS_W-1:0]  SERVO_POS,
    output logic [POS_W-1:0]  BEST_POS,
    output logic              BUSY,
    output logic              DONE,
    output logic              TMO_ERR
);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam int TC_W = $clog2(ADC_TMO + 1);

    localparam logic [POS_W-1:0] POS_FIRST   = POS_W'(POS_MIN);
    localparam logic [POS_W:0]   POS_LAST    = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   STEP_INC    = (POS_W+1)'(STEP);
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYC - 1);
    localparam logic [TC_W-1:0]  TMO_LAST    = TC_W'(ADC_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_SETTLE, S_REQ, S_WAIT, S_CMP, S_PARK, S_DONE
    } state_t;

    state_t          state;
    logic            first;
    logic [SC_W-1:0] settle_cnt;
    logic [TC_W-1:0] tmo_cnt;
    logic [POS_W:0]  pos_sum;
    logic            last_step;
    logic            abort_hit;

    // One extra bit so the end-of-range test never sees a wrapped position.
    assign pos_sum   = {1'b0, SERVO_POS} + STEP_INC;
    assign last_step = pos_sum > POS_LAST;
    assign abort_hit = ABORT && (state inside {S_MOVE, S_SETTLE, S_REQ, S_WAIT});

    // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            SERVO_POS      <= POS_FIRST;
            BEST_POS       <= POS_FIRST;
            bus.PV         <= '0;
            bus.GT         <= 1'b0;
            bus.SAMPLE_REQ <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            TMO_ERR        <= 1'b0;
            first          <= 1'b1;
            settle_cnt     <= '0;
            tmo_cnt        <= '0;
        end else begin
            bus.GT         <= 1'b0;
            bus.SAMPLE_REQ <= 1'b0;
            DONE           <= 1'b0;
            if (abort_hit) begin
                state      <= S_PARK;
                settle_cnt <= SETTLE_LOAD;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (START) begin
                            SERVO_POS <= POS_FIRST;
                            first     <= 1'b1;
                            TMO_ERR   <= 1'b0;
                            BUSY      <= 1'b1;
                            state     <= S_MOVE;
                        end
                    end
                    S_MOVE: begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == '0) begin
                            bus.SAMPLE_REQ <= 1'b1;
                            state          <= S_REQ;
                        end else begin
                            settle_cnt <= settle_cnt - SC_W'(1);
                        end
                    end
                    S_REQ: begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.ADC_VALID) begin
                            // LV cannot move before CMP, so the decision is registered
                            // here and GT is high exactly for the CMP cycle.
                            bus.PV <= bus.ADC_DATA;
                            bus.GT <= first || (bus.ADC_DATA > bus.LV);
                            state  <= S_CMP;
                        end else if (tmo_cnt == TMO_LAST) begin
                            TMO_ERR <= 1'b1;
                            if (last_step) begin
                                settle_cnt <= SETTLE_LOAD;
                                state      <= S_PARK;
                            end else begin
                                SERVO_POS <= pos_sum[POS_W-1:0];
                                state     <= S_MOVE;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TC_W'(1);
                        end
                    end
                    S_CMP: begin
                        if (bus.GT) begin
                            BEST_POS <= SERVO_POS;
                            first    <= 1'b0;
                        end
                        if (last_step) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= S_PARK;
                        end else begin
                            SERVO_POS <= pos_sum[POS_W-1:0];
                            state     <= S_MOVE;
                        end
                    end
                    S_PARK: begin
                        SERVO_POS <= BEST_POS;
                        if (settle_cnt == '0) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            settle_cnt <= settle_cnt - SC_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sweep_peak_ctrl.sv
// Directed bench for sweep_peak_ctrl: two instances (unit step 0..4, step 2 over 0..5)
// with an ADC responder and a holding-register model driven from the stimulus tasks.
module tb_sweep_peak_ctrl;
    localparam int SETTLE_T = 3;

    logic       CLK = 1'b0;
    logic       RST, START_A, ABORT_A, START_B, ABORT_B;
    logic [7:0] pos_a, best_a, pos_b, best_b;
    logic       busy_a, done_a, tmo_a, busy_b, done_b, tmo_b;

    sweep_peak_ctrl_if bus_a ();
    sweep_peak_ctrl_if bus_b ();

    always #5 CLK = ~CLK;

    sweep_peak_ctrl #(.POS_W(8), .POS_MIN(0), .POS_MAX(4), .STEP(1),
                      .SETTLE_CYC(SETTLE_T), .ADC_TMO(8)) dut_a (
        .CLK(CLK), .RST(RST), .START(START_A), .ABORT(ABORT_A), .bus(bus_a),
        .SERVO_POS(pos_a), .BEST_POS(best_a), .BUSY(busy_a), .DONE(done_a), .TMO_ERR(tmo_a)
    );

    sweep_peak_ctrl #(.POS_W(8), .POS_MIN(0), .POS_MAX(5), .STEP(2),
                      .SETTLE_CYC(SETTLE_T), .ADC_TMO(8)) dut_b (
        .CLK(CLK), .RST(RST), .START(START_B), .ABORT(ABORT_B), .bus(bus_b),
        .SERVO_POS(pos_b), .BEST_POS(best_b), .BUSY(busy_b), .DONE(done_b), .TMO_ERR(tmo_b)
    );

    int         total = 0;
    int         bad = 0;
    logic [9:0] samp_a [8];
    logic [9:0] samp_b [8];
    logic [7:0] mute_a;
    logic       stray_a;
    logic [9:0] stray_data_a;
    int         cd_a, cd_b;
    int         gt_cnt_a, req_cnt_a, done_cnt_a, since_a;
    logic [7:0] gt_mask_a, req_mask_a;
    logic       busy_prev_a;
    logic [7:0] pos_prev_a;
    int         req_cnt_b, done_cnt_b, max_pos_b;
    logic [7:0] req_mask_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        gt_cnt_a = 0; req_cnt_a = 0; done_cnt_a = 0;
        gt_mask_a = '0; req_mask_a = '0; cd_a = 0;
        req_cnt_b = 0; done_cnt_b = 0; max_pos_b = 0; req_mask_b = '0; cd_b = 0;
    endtask

    // One clock: holding registers capture PV on GT, then outputs are logged at the
    // falling edge and the ADC responders drive the next inputs.
    task automatic cyc();
        logic       gt_a0, gt_b0, fire_a, fire_b;
        logic [9:0] pv_a0, pv_b0;
        gt_a0 = bus_a.GT; pv_a0 = bus_a.PV;
        gt_b0 = bus_b.GT; pv_b0 = bus_b.PV;
        @(posedge CLK);
        #1;
        if (gt_a0) bus_a.LV = pv_a0;
        if (gt_b0) bus_b.LV = pv_b0;
        @(negedge CLK);

        if (bus_a.GT) begin gt_cnt_a++; gt_mask_a[pos_a[2:0]] = 1'b1; end
        if ((busy_a && !busy_prev_a) || pos_a != pos_prev_a) since_a = 1;
        else since_a++;
        busy_prev_a = busy_a;
        pos_prev_a  = pos_a;
        if (bus_a.SAMPLE_REQ) begin
            req_cnt_a++;
            req_mask_a[pos_a[2:0]] = 1'b1;
            check("settle_len_a", since_a, SETTLE_T + 2);
        end
        if (done_a) done_cnt_a++;
        fire_a = 1'b0;
        if (cd_a > 0) begin cd_a--; fire_a = (cd_a == 0); end
        if (bus_a.SAMPLE_REQ && !mute_a[pos_a[2:0]]) cd_a = 2;
        bus_a.ADC_VALID = fire_a | stray_a;
        bus_a.ADC_DATA  = fire_a ? samp_a[pos_a[2:0]] : stray_data_a;

        if (bus_b.SAMPLE_REQ) begin req_cnt_b++; req_mask_b[pos_b[2:0]] = 1'b1; end
        if (int'(pos_b) > max_pos_b) max_pos_b = int'(pos_b);
        if (done_b) done_cnt_b++;
        fire_b = 1'b0;
        if (cd_b > 0) begin cd_b--; fire_b = (cd_b == 0); end
        if (bus_b.SAMPLE_REQ) cd_b = 2;
        bus_b.ADC_VALID = fire_b;
        bus_b.ADC_DATA  = fire_b ? samp_b[pos_b[2:0]] : 10'd0;
    endtask

    task automatic wait_done(input bit on_b, input int max_cyc);
        int n;
        n = 0;
        while ((on_b ? done_cnt_b : done_cnt_a) == 0 && n < max_cyc) begin
            cyc();
            n++;
        end
        check(on_b ? "done_seen_b" : "done_seen_a", (on_b ? done_cnt_b : done_cnt_a) != 0, 1);
    endtask

    initial begin
        int n;
        RST = 1'b1; START_A = 1'b0; ABORT_A = 1'b0; START_B = 1'b0; ABORT_B = 1'b0;
        bus_a.ADC_VALID = 1'b0; bus_a.ADC_DATA = '0; bus_a.LV = '0;
        bus_b.ADC_VALID = 1'b0; bus_b.ADC_DATA = '0; bus_b.LV = '0;
        for (int i = 0; i < 8; i++) begin samp_a[i] = '0; samp_b[i] = '0; end
        mute_a = '0; stray_a = 1'b0; stray_data_a = '0;
        since_a = 0; busy_prev_a = 1'b0; pos_prev_a = '0;
        clear_logs();
        @(negedge CLK);
        cyc(); cyc();

        check("rst_servo_a", pos_a, 0);
        check("rst_best_a", best_a, 0);
        check("rst_pv_a", bus_a.PV, 0);
        check("rst_flags_a", {bus_a.GT, bus_a.SAMPLE_REQ, busy_a, done_a, tmo_a}, 0);
        check("rst_busy_b", {busy_b, pos_b}, 0);
        RST = 1'b0;
        cyc();

        // Basic sweep: peaks at 0 and 1, tie at 3 keeps position 1.
        samp_a[0] = 100; samp_a[1] = 300; samp_a[2] = 250; samp_a[3] = 300; samp_a[4] = 50;
        clear_logs();
        START_A = 1'b1; cyc(); START_A = 1'b0;
        check("busy_after_start", busy_a, 1);
        wait_done(1'b0, 300);
        check("done_pulse_width", done_a, 1);
        cyc(); cyc(); cyc();
        check("basic_gt_mask", gt_mask_a, 8'b0000_0011);
        check("basic_gt_cnt", gt_cnt_a, 2);
        check("basic_req_cnt", req_cnt_a, 5);
        check("basic_best", best_a, 1);
        check("basic_park", pos_a, 1);
        check("basic_done_once", done_cnt_a, 1);
        check("basic_idle", {busy_a, done_a, tmo_a}, 0);
        check("basic_lv", bus_a.LV, 300);

        // Timeout at position 2; first sample still captures despite LV=300.
        samp_a[0] = 100; samp_a[1] = 200; samp_a[2] = 999; samp_a[3] = 300; samp_a[4] = 50;
        mute_a = 8'b0000_0100;
        clear_logs();
        START_A = 1'b1; cyc(); START_A = 1'b0;
        wait_done(1'b0, 400);
        check("tmo_err_set", tmo_a, 1);
        check("tmo_gt_mask", gt_mask_a, 8'b0000_1011);
        check("tmo_req_mask", req_mask_a, 8'b0001_1111);
        check("tmo_best", best_a, 3);
        check("tmo_park", pos_a, 3);

        // Abort while settling at position 3 after peaks at 0 and 2.
        mute_a = '0;
        samp_a[0] = 100; samp_a[1] = 50; samp_a[2] = 200; samp_a[3] = 999; samp_a[4] = 999;
        clear_logs();
        START_A = 1'b1; cyc(); START_A = 1'b0;
        check("tmo_err_cleared", tmo_a, 0);
        n = 0;
        while (pos_a != 8'd3 && n < 200) begin cyc(); n++; end
        check("abort_reach_pos3", pos_a, 3);
        cyc();
        ABORT_A = 1'b1; cyc(); ABORT_A = 1'b0;
        check("abort_busy_park", busy_a, 1);
        wait_done(1'b0, 50);
        check("abort_req_cnt", req_cnt_a, 3);
        check("abort_gt_mask", gt_mask_a, 8'b0000_0101);
        check("abort_best", best_a, 2);
        check("abort_park", pos_a, 2);
        check("abort_lv", bus_a.LV, 200);

        // Reset in WAIT followed by a stray ADC_VALID.
        mute_a = 8'hFF;
        clear_logs();
        START_A = 1'b1; cyc(); START_A = 1'b0;
        n = 0;
        while (req_cnt_a == 0 && n < 50) begin cyc(); n++; end
        check("rst_test_req_seen", req_cnt_a, 1);
        cyc();
        RST = 1'b1; stray_a = 1'b1; stray_data_a = 10'd500;
        cyc();
        RST = 1'b0; stray_a = 1'b0; stray_data_a = '0;
        cyc();
        check("midrst_servo", pos_a, 0);
        check("midrst_best", best_a, 0);
        check("midrst_pv", bus_a.PV, 0);
        check("midrst_flags", {bus_a.GT, bus_a.SAMPLE_REQ, busy_a, done_a, tmo_a}, 0);
        check("midrst_no_gt", gt_cnt_a, 0);

        // All-zero samples against stale LV=900; START mid-sweep is ignored.
        mute_a = '0;
        for (int i = 0; i < 8; i++) samp_a[i] = '0;
        bus_a.LV = 10'd900;
        clear_logs();
        START_A = 1'b1; cyc(); START_A = 1'b0;
        n = 0;
        while (pos_a != 8'd2 && n < 200) begin cyc(); n++; end
        START_A = 1'b1; cyc(); START_A = 1'b0;
        wait_done(1'b0, 300);
        check("zero_gt_cnt", gt_cnt_a, 1);
        check("zero_gt_mask", gt_mask_a, 8'b0000_0001);
        check("zero_best", best_a, 0);
        check("zero_park", pos_a, 0);
        check("zero_req_cnt", req_cnt_a, 5);
        check("zero_lv", bus_a.LV, 0);

        // Non-aligned range: 0,2,4 then park without visiting 6.
        samp_b[0] = 10; samp_b[2] = 20; samp_b[4] = 30;
        clear_logs();
        START_B = 1'b1; cyc(); START_B = 1'b0;
        wait_done(1'b1, 300);
        cyc();
        check("step2_req_mask", req_mask_b, 8'b0001_0101);
        check("step2_req_cnt", req_cnt_b, 3);
        check("step2_max_pos", max_pos_b, 4);
        check("step2_best", best_b, 4);
        check("step2_park", pos_b, 4);
        check("step2_done_once", done_cnt_b, 1);
        check("step2_idle", {busy_b, tmo_b}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sweep_peak_ctrl.md
Name: sweep_peak_ctrl

Overview:
Sequencer for the max-voltage holding register and its comparator path in the panel tracker. It sweeps the servo across a position range and waits for mechanical settling at each step. It then requests one ADC sample, compares it with the stored maximum LV and pulses GT to capture new peaks along with their position. At sweep end it parks the servo at the best position and reports completion.

Parameters:
POS_W, 8, servo position width
POS_MIN, 0, first sweep position
POS_MAX, 180, last sweep position (inclusive)
STEP, 1, position increment per step (>0)
SETTLE_CYC, 50000, settling cycles after each move (>=1)
ADC_TMO, 1024, max cycles waiting for ADC_VALID

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
START  in  1  begin sweep (sampled in IDLE/DONE only)
ABORT  in  1  stop sweep, park at best position so far
ADC_DATA  in  10  raw sample, upper 10 bits of ADC
ADC_VALID  in  1  one-cycle strobe, ADC_DATA valid
LV  in  10  stored maximum from holding register
SAMPLE_REQ  out  1  one-cycle ADC conversion request
PV  out  10  pending value to holding register
GT  out  1  capture enable to holding register (one-cycle pulse)
SERVO_POS  out  POS_W  commanded servo position
BEST_POS  out  POS_W  position of current maximum
BUSY  out  1  sweep in progress (MOVE..PARK)
DONE  out  1  one-cycle pulse on entering DONE
TMO_ERR  out  1  sticky: at least one sample timed out this sweep

Behaviour:
- Reset, synchronous and active-high: state IDLE; SERVO_POS=POS_MIN; BEST_POS=POS_MIN; PV=0; GT=0; SAMPLE_REQ=0; BUSY=0; DONE=0; TMO_ERR=0; internal first-flag=1; counters=0.
- States: IDLE, MOVE, SETTLE, REQ, WAIT, CMP, PARK, DONE.
- IDLE/DONE + START=1: SERVO_POS<=POS_MIN; first-flag<=1; TMO_ERR<=0; go to MOVE.
- MOVE (1 cycle): load settle counter with SETTLE_CYC-1, then go to SETTLE.
- SETTLE: decrement the counter. At 0, go to REQ. Exactly SETTLE_CYC cycles are spent in SETTLE.
- REQ (1 cycle): SAMPLE_REQ=1; clear the timeout counter; go to WAIT.
- WAIT: on ADC_VALID, PV<=ADC_DATA and go to CMP.
  - If ADC_TMO cycles pass without ADC_VALID: set TMO_ERR and skip the compare. Go to the step advance and do not pulse GT.
  - An ADC_VALID that arrives outside WAIT is ignored.
- CMP (1 cycle): if first-flag=1 or PV > LV (strict, unsigned), then:
  - GT=1 for this cycle;
  - BEST_POS<=SERVO_POS;
  - first-flag<=0.
  - Ties keep the earlier position.
  - LV reflects the new value from the following cycle; the controller never compares in the cycle after GT.
- Step advance (after CMP or timeout):
  - If SERVO_POS+STEP > POS_MAX (evaluated at POS_W+1 bits, no wrap), go to PARK.
  - Otherwise SERVO_POS<=SERVO_POS+STEP and go to MOVE.
- PARK:
  - SERVO_POS<=BEST_POS; load the settle counter; wait SETTLE_CYC cycles; then go to DONE.
  - If no sample ever succeeded (first-flag still 1), BEST_POS stays POS_MIN.
- DONE: DONE=1 for the single entry cycle. Outputs hold; BUSY=0. START restarts the sweep.
- ABORT=1 in any of MOVE..WAIT: go to PARK at the next edge. A pending WAIT sample is dropped and no GT is issued. ABORT is ignored in CMP (it takes effect after CMP), PARK, IDLE and DONE.
- START while BUSY=1 is ignored.
- RST mid-sweep returns to the reset values in the same edge; the holding register is not cleared, and first-flag guarantees the next sweep overwrites it.
- GT is never asserted outside CMP. SAMPLE_REQ is never asserted outside REQ.
- BUSY=1 in MOVE, SETTLE, REQ, WAIT, CMP and PARK.

Test Plan:
- Basic sweep (POS_MIN=0, POS_MAX=4, STEP=1, SETTLE_CYC=3; ADC returns 100,300,250,300,50 two cycles after each REQ; LV modelled by a register) -> GT pulses at pos 0 and 1 only; BEST_POS=1; SERVO_POS parks at 1; DONE pulses once; 5 SAMPLE_REQ pulses, each preceded by exactly 3 SETTLE cycles.
- Non-aligned range (POS_MAX=5, STEP=2) -> positions 0,2,4 sampled; no overshoot to 6; ends in PARK.
- Timeout (ADC_TMO=8; no ADC_VALID at pos 2) -> TMO_ERR=1; no GT at pos 2; sweep continues to pos 3; TMO_ERR clears on the next START.
- ABORT in SETTLE at pos 3 after peaks at 0 and 2 -> no further SAMPLE_REQ; SERVO_POS=2 after PARK; DONE pulse follows.
- RST asserted in WAIT, stray ADC_VALID the next cycle -> all outputs at reset values; no GT; new START gives first-sample GT even if ADC_DATA=0 < stale LV=900.
- All-zero samples -> GT only at pos 0; BEST_POS=0; START ignored while BUSY=1.
